// File: rtl/branch_pkg.sv
// Shared branch definitions: opcode/funct3 constants, 2-bit counter
// encodings and the predictor table entry layout.
package branch_pkg;

   localparam logic [6:0] B_TYPE = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BLTU = 3'b110;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Tag is held right-aligned in a fixed 30-bit field so the entry type
   // does not depend on the table size; unused upper bits stay zero.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      ctr_t        ctr;
   } bp_entry_t;

   // Tag of a PC for a table with idx_w index bits: pc[31:idx_w+2].
   function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
      return 30'(pc >> (idx_w + 2));
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
   import branch_pkg::*;
(
   input  ctr_t ctr,
   input  logic taken,
   output ctr_t ctr_next
);

   // Step toward ST on taken, toward SNT on not taken, holding at the ends.
   always_comb begin
      ctr_next = ctr;
      unique case (ctr)
         SNT: ctr_next = taken ? WNT : SNT;
         WNT: ctr_next = taken ? WT  : SNT;
         WT:  ctr_next = taken ? ST  : WNT;
         ST:  ctr_next = taken ? ST  : WT;
         default: ctr_next = ctr;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Zero-latency lookup for
// IF, single-cycle resolve/update from EX with mispredict and redirect.
module branch_predictor
   import branch_pkg::*;
#(
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   output logic        pred_taken,
   output logic [31:0] pred_next_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [6:0]  upd_opcode,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_pc,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_cnt,
   output logic [31:0] mp_cnt
);

   bp_entry_t        bp_tab [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   bp_entry_t        lk_e;
   logic             lk_hit;

   logic [IDX_W-1:0] up_idx;
   bp_entry_t        up_e;
   logic             up_hit;
   logic             is_btype;
   logic             br_upd;
   logic             nb_fix;
   ctr_t             up_ctr_next;

   // Fetch-side lookup from registered table contents.
   always_comb begin
      lk_idx       = pc_if[IDX_W+1:2];
      lk_e         = bp_tab[lk_idx];
      lk_hit       = lk_e.valid && (lk_e.tag == pc_tag(pc_if, IDX_W));
      pred_taken   = lk_hit && lk_e.ctr[1];
      pred_next_pc = pred_taken ? lk_e.target : pc_if + 32'd4;
   end

   // Resolve-side decode, mispredict detection and redirect target.
   always_comb begin
      up_idx   = upd_pc[IDX_W+1:2];
      up_e     = bp_tab[up_idx];
      up_hit   = up_e.valid && (up_e.tag == pc_tag(upd_pc, IDX_W));
      is_btype = (upd_opcode == B_TYPE);
      br_upd   = upd_valid && is_btype;
      nb_fix   = upd_valid && !is_btype && upd_pred_taken;

      mispredict = 1'b0;
      if (br_upd)
         mispredict = (upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_pc));
      else if (upd_valid)
         mispredict = upd_pred_taken;

      redirect_pc = (is_btype && upd_taken) ? upd_target : upd_pc + 32'd4;
   end

   sat_counter2 u_ctr (
      .ctr      (up_e.ctr),
      .taken    (upd_taken),
      .ctr_next (up_ctr_next)
   );

   // Table write-back and statistics; reset wins over any update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bp_tab[i].valid <= 1'b0;
            bp_tab[i].ctr   <= WNT;
         end
         br_cnt <= 32'd0;
         mp_cnt <= 32'd0;
      end else begin
         if (br_upd) begin
            br_cnt <= br_cnt + 32'd1;
            if (up_hit) begin
               bp_tab[up_idx].ctr <= up_ctr_next;
               if (upd_taken)
                  bp_tab[up_idx].target <= upd_target;
            end else if (upd_taken) begin
               bp_tab[up_idx].valid  <= 1'b1;
               bp_tab[up_idx].tag    <= pc_tag(upd_pc, IDX_W);
               bp_tab[up_idx].target <= upd_target;
               bp_tab[up_idx].ctr    <= WT;
            end
         end else if (nb_fix && up_hit) begin
            // A non-branch was predicted taken through a stale alias.
            bp_tab[up_idx].valid <= 1'b0;
         end
         if (mispredict)
            mp_cnt <= mp_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor: allocation, counter hysteresis,
// aliasing, target correction, stale-alias invalidation and reset.
module tb_branch_predictor;
   import branch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [6:0]  upd_opcode;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_pc;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] br_cnt;
   logic [31:0] mp_cnt;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] OP_IMM = 7'b0010011;

   branch_predictor dut (
      .clk            (clk),
      .rst            (rst),
      .pc_if          (pc_if),
      .pred_taken     (pred_taken),
      .pred_next_pc   (pred_next_pc),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_opcode     (upd_opcode),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_pred_taken (upd_pred_taken),
      .upd_pred_pc    (upd_pred_pc),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .br_cnt         (br_cnt),
      .mp_cnt         (mp_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic [31:0] pc, input logic [6:0] op, input logic tk,
                      input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_opcode     = op;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_pred_taken = ptk;
      upd_pred_pc    = ppc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      #1;
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic exp_tk, input logic [31:0] exp_pc);
      pc_if = pc;
      #1;
      chk({tag, "_tk"}, {31'd0, pred_taken}, {31'd0, exp_tk});
      chk({tag, "_pc"}, pred_next_pc, exp_pc);
   endtask

   task automatic cnts(input string tag, input logic [31:0] eb, input logic [31:0] em);
      chk({tag, "_br"}, br_cnt, eb);
      chk({tag, "_mp"}, mp_cnt, em);
   endtask

   task automatic mp(input string tag, input logic exp_mp, input logic [31:0] exp_rd);
      chk({tag, "_mp"}, {31'd0, mispredict}, {31'd0, exp_mp});
      if (exp_mp) chk({tag, "_rd"}, redirect_pc, exp_rd);
   endtask

   initial begin
      rst = 1'b1; pc_if = 32'h100;
      upd_valid = 1'b0; upd_pc = 32'h0; upd_opcode = 7'h0; upd_taken = 1'b0;
      upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;

      look("rst_lk", 32'h100, 1'b0, 32'h104);
      cnts("rst", 32'd0, 32'd0);
      chk("rst_mp", {31'd0, mispredict}, 32'd0);

      // First taken resolve allocates at WT.
      upd(32'h100, B_TYPE, 1'b1, 32'h80, 1'b0, 32'h104);
      mp("alloc", 1'b1, 32'h80);
      tick();
      look("alloc_lk", 32'h100, 1'b1, 32'h80);
      cnts("alloc", 32'd1, 32'd1);

      // Three more taken: correctly predicted; lookup during update sees old state.
      for (int i = 0; i < 3; i++) begin
         upd(32'h100, B_TYPE, 1'b1, 32'h80, 1'b1, 32'h80);
         mp("tk3", 1'b0, 32'h0);
         tick();
      end
      cnts("tk3", 32'd4, 32'd1);

      // ST -> WT: still predicts taken.
      upd(32'h100, B_TYPE, 1'b0, 32'h80, 1'b1, 32'h80);
      mp("nt1", 1'b1, 32'h104);
      look("nt1_same_cyc", 32'h100, 1'b1, 32'h80);
      tick();
      look("nt1_lk", 32'h100, 1'b1, 32'h80);

      // WT -> WNT: now predicts fall-through.
      upd(32'h100, B_TYPE, 1'b0, 32'h80, 1'b1, 32'h80);
      mp("nt2", 1'b1, 32'h104);
      tick();
      look("nt2_lk", 32'h100, 1'b0, 32'h104);
      cnts("nt2", 32'd6, 32'd3);

      // 0x140 aliases index 0 with a different tag and replaces 0x100.
      look("alias_pre", 32'h140, 1'b0, 32'h144);
      upd(32'h140, B_TYPE, 1'b1, 32'h400, 1'b0, 32'h144);
      mp("alias", 1'b1, 32'h400);
      tick();
      look("alias_100", 32'h100, 1'b0, 32'h104);
      look("alias_140", 32'h140, 1'b1, 32'h400);

      // Direction right, target wrong: redirect and retarget.
      upd(32'h200, B_TYPE, 1'b1, 32'h280, 1'b0, 32'h204);
      tick();
      upd(32'h200, B_TYPE, 1'b1, 32'h300, 1'b1, 32'h280);
      mp("tgt", 1'b1, 32'h300);
      tick();
      look("tgt_lk", 32'h200, 1'b1, 32'h300);
      cnts("tgt", 32'd9, 32'd6);

      // Non-branch predicted taken: flush and invalidate.
      upd(32'h200, OP_IMM, 1'b0, 32'h0, 1'b1, 32'h300);
      mp("nb", 1'b1, 32'h204);
      tick();
      look("nb_lk", 32'h200, 1'b0, 32'h204);
      cnts("nb", 32'd9, 32'd7);

      // Non-branch predicted not taken: nothing to do.
      upd(32'h204, OP_IMM, 1'b0, 32'h0, 1'b0, 32'h208);
      mp("nb_ok", 1'b0, 32'h0);
      tick();

      // Miss and not taken: no allocation, but counted.
      upd(32'h300, B_TYPE, 1'b0, 32'h500, 1'b0, 32'h304);
      mp("miss_nt", 1'b0, 32'h0);
      tick();
      look("miss_nt_lk", 32'h300, 1'b0, 32'h304);
      cnts("miss_nt", 32'd10, 32'd7);

      // Invalid EX slot never mispredicts nor counts.
      upd(32'h300, B_TYPE, 1'b1, 32'h500, 1'b0, 32'h304);
      upd_valid = 1'b0;
      #1;
      mp("inval", 1'b0, 32'h0);
      tick();
      cnts("inval", 32'd10, 32'd7);
      look("inval_lk", 32'h300, 1'b0, 32'h304);

      // PC+4 wraps.
      look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

      // Reset dominates a simultaneous taken update.
      rst = 1'b1;
      upd(32'h100, B_TYPE, 1'b1, 32'h80, 1'b0, 32'h104);
      tick();
      rst = 1'b0;
      #1;
      look("rstupd_100", 32'h100, 1'b0, 32'h104);
      look("rstupd_140", 32'h140, 1'b0, 32'h144);
      cnts("rstupd", 32'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
